// File: rtl/vector_sequencer_pkg.sv
// Shared types for the vector sequencer: controller state encoding and a
// counter-width helper that never returns zero.
package vector_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CONFIG = 3'd1,
    RESET  = 3'd2,
    RUN    = 3'd3,
    DRAIN  = 3'd4,
    DONE   = 3'd5
  } seq_state_t;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vector_sequencer_config_regfile.sv
// Configuration register file: one write port, every register visible at
// once on a flattened bus, asynchronously cleared.
module config_regfile #(
  parameter int data_width = 32,
  parameter int reg_count  = 32,
  parameter int addr_width = 5
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            wr_en,
  input  logic [addr_width-1:0]           wr_addr,
  input  logic [data_width-1:0]           wr_data,
  output logic [reg_count*data_width-1:0] regs_flat
);

  genvar gi;
  generate
    for (gi = 0; gi < reg_count; gi++) begin : g_reg
      logic [data_width-1:0] word_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          word_reg <= '0;
        end else if (wr_en && (wr_addr == addr_width'(gi))) begin
          word_reg <= wr_data;
        end
      end

      assign regs_flat[gi*data_width +: data_width] = word_reg;
    end
  endgenerate

endmodule

// File: rtl/vector_sequencer.sv
// Sequences one DUT run: load configuration words, hold the DUT in reset,
// stream stimulus vectors and return sampled responses.
// Optional RUN watchdog enabled by defining VECTOR_SEQUENCER_TIMEOUT_EN.
module vector_sequencer
  import vector_sequencer_pkg::*;
#(
  parameter int register_size      = 32,
  parameter int register_count     = 32,
  parameter int input_vector_size  = 32,
  parameter int output_vector_size = 32,
  parameter int reset_cycles       = 5,
  parameter int max_cycles         = 10000
) (
  input  logic                                    clk,
  input  logic                                    logic_reset_n,
  input  logic                                    start,
  input  logic [register_size-1:0]                cfg_data,
  input  logic                                    cfg_valid,
  output logic                                    cfg_ready,
  output logic [register_count*register_size-1:0] config_regs,
  output logic                                    dut_reset,
  input  logic [input_vector_size-1:0]            in_data,
  input  logic                                    in_valid,
  input  logic                                    in_last,
  output logic                                    in_ready,
  output logic [input_vector_size-1:0]            input_vector,
  input  logic [output_vector_size-1:0]           dut_output,
  output logic [output_vector_size-1:0]           out_data,
  output logic                                    out_valid,
  output logic                                    busy,
  output logic                                    done,
  output logic                                    timeout
);

  localparam int CfgW = cnt_width(register_count);
  localparam int RstW = cnt_width(reset_cycles);

  seq_state_t      state_reg, state_next;
  logic [CfgW-1:0] cfg_cnt_reg;
  logic [RstW-1:0] rst_cnt_reg;
  logic            drain_cnt_reg;
  logic            xfer_pending_reg;
  logic            run_expired;
  logic            cfg_xfer, in_xfer, cfg_last, rst_last;

  assign cfg_xfer = cfg_valid & cfg_ready;
  assign in_xfer  = in_valid & in_ready;
  assign cfg_last = (cfg_cnt_reg == CfgW'(register_count - 1));
  assign rst_last = (rst_cnt_reg == RstW'(reset_cycles - 1));

  always_ff @(posedge clk or negedge logic_reset_n) begin
    if (!logic_reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, DONE: if (start) state_next = CONFIG;
      CONFIG:     if (cfg_xfer && cfg_last) state_next = RESET;
      RESET:      if (rst_last) state_next = RUN;
      RUN: begin
        // The watchdog wins over a simultaneous in_last.
        if (run_expired) state_next = DONE;
        else if (in_xfer && in_last) state_next = DRAIN;
      end
      DRAIN:      if (drain_cnt_reg) state_next = DONE;
      default:    state_next = IDLE;
    endcase
  end

  always_comb begin
    cfg_ready = (state_reg == CONFIG);
    in_ready  = (state_reg == RUN);
    dut_reset = (state_reg == IDLE) || (state_reg == CONFIG) || (state_reg == RESET);
    busy      = (state_reg != IDLE) && (state_reg != DONE);
    done      = (state_reg == DONE);
  end

  // Phase counters restart whenever their phase is not active.
  always_ff @(posedge clk or negedge logic_reset_n) begin
    if (!logic_reset_n) begin
      cfg_cnt_reg   <= '0;
      rst_cnt_reg   <= '0;
      drain_cnt_reg <= 1'b0;
    end else begin
      cfg_cnt_reg   <= (state_reg != CONFIG) ? '0 : (cfg_xfer ? cfg_cnt_reg + 1'b1 : cfg_cnt_reg);
      rst_cnt_reg   <= (state_reg == RESET) ? rst_cnt_reg + 1'b1 : '0;
      drain_cnt_reg <= (state_reg == DRAIN) ? ~drain_cnt_reg : 1'b0;
    end
  end

  // The response to a transfer is sampled one edge after the vector is applied.
  always_ff @(posedge clk or negedge logic_reset_n) begin
    if (!logic_reset_n) begin
      input_vector     <= '0;
      xfer_pending_reg <= 1'b0;
      out_data         <= '0;
      out_valid        <= 1'b0;
    end else begin
      xfer_pending_reg <= in_xfer;
      out_valid        <= xfer_pending_reg;
      if (in_xfer) input_vector <= in_data;
      if (xfer_pending_reg) out_data <= dut_output;
    end
  end

`ifdef VECTOR_SEQUENCER_TIMEOUT_EN
  localparam int RunW = $clog2(max_cycles + 1);

  logic [RunW-1:0] run_cnt_reg;
  logic            timeout_reg;

  assign run_expired = (state_reg == RUN) && (run_cnt_reg == RunW'(max_cycles - 1));
  assign timeout     = timeout_reg;

  always_ff @(posedge clk or negedge logic_reset_n) begin
    if (!logic_reset_n) begin
      run_cnt_reg <= '0;
      timeout_reg <= 1'b0;
    end else begin
      run_cnt_reg <= (state_reg == RUN) ? run_cnt_reg + 1'b1 : '0;
      if (start && ((state_reg == IDLE) || (state_reg == DONE))) timeout_reg <= 1'b0;
      else if (run_expired) timeout_reg <= 1'b1;
    end
  end
`else
  assign run_expired = 1'b0;
  assign timeout     = 1'b0;
`endif

  config_regfile #(
    .data_width (register_size),
    .reg_count  (register_count),
    .addr_width (CfgW)
  ) u_regfile (
    .clk       (clk),
    .rst_n     (logic_reset_n),
    .wr_en     (cfg_xfer),
    .wr_addr   (cfg_cnt_reg),
    .wr_data   (cfg_data),
    .regs_flat (config_regs)
  );

endmodule

// File: tb/tb_vector_sequencer.sv
// Self-checking bench for vector_sequencer; the DUT stand-in computes
// output = input + 1 combinationally.
module tb_vector_sequencer;

  localparam int RS   = 32;
  localparam int RC   = 32;
  localparam int IVS  = 32;
  localparam int OVS  = 32;
  localparam int RCYC = 5;
`ifdef VECTOR_SEQUENCER_TIMEOUT_EN
  localparam int MAXC  = 8;
  localparam bit TO_EN = 1'b1;
`else
  localparam int MAXC  = 10000;
  localparam bit TO_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              logic_reset_n = 1'b0;
  logic              start = 1'b0;
  logic [RS-1:0]     cfg_data = '0;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic [RC*RS-1:0]  config_regs;
  logic              dut_reset;
  logic [IVS-1:0]    in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_last = 1'b0;
  logic              in_ready;
  logic [IVS-1:0]    input_vector;
  logic [OVS-1:0]    dut_output;
  logic [OVS-1:0]    out_data;
  logic              out_valid;
  logic              busy;
  logic              done;
  logic              timeout;

  int checks = 0;
  int errors = 0;

  logic [RS-1:0] cfg_words [RC];
  logic [RS-1:0] exp_regs  [RC];

  vector_sequencer #(
    .register_size      (RS),
    .register_count     (RC),
    .input_vector_size  (IVS),
    .output_vector_size (OVS),
    .reset_cycles       (RCYC),
    .max_cycles         (MAXC)
  ) dut (
    .clk           (clk),
    .logic_reset_n (logic_reset_n),
    .start         (start),
    .cfg_data      (cfg_data),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .config_regs   (config_regs),
    .dut_reset     (dut_reset),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_last       (in_last),
    .in_ready      (in_ready),
    .input_vector  (input_vector),
    .dut_output    (dut_output),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .busy          (busy),
    .done          (done),
    .timeout       (timeout)
  );

  assign dut_output = input_vector + 32'd1;

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_cfg_ready"}, cfg_ready, 0);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_config_regs_zero"}, (config_regs == '0), 1);
    check({tag, "_dut_reset"}, dut_reset, 1);
    check({tag, "_input_vector"}, input_vector, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_timeout"}, timeout, 0);
  endtask

  task automatic start_seq();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_cfg_ready", cfg_ready, 1);
    check("start_busy", busy, 1);
    check("start_dut_reset", dut_reset, 1);
    check("start_timeout_cleared", timeout, 0);
  endtask

  // Offer cfg_words; the model accepts a word whenever valid is offered while
  // fewer than RC words have been taken. Then offer one surplus word.
  task automatic feed_config(input bit gaps);
    int accepted = 0;
    int guard = 0;
    while (accepted < RC && guard < 1000) begin
      cfg_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      cfg_data  = cfg_words[accepted];
      check("cfg_ready_open", cfg_ready, 1);
      tick();
      if (cfg_valid) begin
        exp_regs[accepted] = cfg_words[accepted];
        accepted++;
      end
      guard++;
    end
    check("cfg_word_count", accepted, RC);
    cfg_valid = 1'b1;
    cfg_data  = 32'hDEAD_BEEF;
    check("cfg_ready_closed", cfg_ready, 0);
  endtask

  // Entered just after the last config edge; counts samples with dut_reset high.
  task automatic reset_window();
    int n = 0;
    while (dut_reset === 1'b1 && n < 50) begin
      check("in_ready_during_reset", in_ready, 0);
      n++;
      tick();
    end
    cfg_valid = 1'b0;
    check("dut_reset_len", n, RCYC);
    check("in_ready_after_reset", in_ready, 1);
    check("cfg_ready_after_reset", cfg_ready, 0);
    for (int i = 0; i < RC; i++) begin
      logic [RS-1:0] got;
      got = config_regs[i*RS +: RS];
      check($sformatf("config_reg_%0d", i), got, exp_regs[i]);
    end
  endtask

  typedef struct {
    logic        v;
    logic        last;
    logic [31:0] d;
    logic [31:0] exp_iv;
    logic        exp_ov;
    logic [31:0] exp_od;
    logic        exp_rdy;
    logic        exp_done;
  } vec_t;

  vec_t tbl [7];

  initial begin
    int target, sent, guard, n;
    logic prev_xfer, xfer;
    logic [31:0] prev_val, iv_model, to_data;

    tbl[0] = '{1'b1, 1'b0, 32'h10, 32'h10, 1'b0, 32'h0,  1'b1, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 32'hAA, 32'h10, 1'b1, 32'h11, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 32'hBB, 32'h10, 1'b0, 32'h0,  1'b1, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 32'h11, 32'h11, 1'b0, 32'h0,  1'b1, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 32'h12, 32'h12, 1'b1, 32'h12, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 32'h77, 32'h12, 1'b1, 32'h13, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 32'h0,  32'h12, 1'b0, 32'h0,  1'b0, 1'b1};

    for (int i = 0; i < RC; i++) exp_regs[i] = '0;

    // Reset state
    #2;
    check_reset_values("por");
    tick();
    tick();
    logic_reset_n = 1'b1;
    tick();
    check_reset_values("idle");

    // Deterministic configuration 0..31, then the stimulus table
    for (int i = 0; i < RC; i++) cfg_words[i] = 32'(i);
    start_seq();
    feed_config(1'b0);
    reset_window();
    for (int r = 0; r < 7; r++) begin
      in_valid = tbl[r].v;
      in_last  = tbl[r].last;
      in_data  = tbl[r].d;
      tick();
      $display("vec %0d: in_valid=%0b data=%h -> input_vector=%h out_valid=%0b out_data=%h",
               r, tbl[r].v, tbl[r].d, input_vector, out_valid, out_data);
      check($sformatf("tbl%0d_input_vector", r), input_vector, tbl[r].exp_iv);
      check($sformatf("tbl%0d_out_valid", r), out_valid, tbl[r].exp_ov);
      if (tbl[r].exp_ov) check($sformatf("tbl%0d_out_data", r), out_data, tbl[r].exp_od);
      check($sformatf("tbl%0d_in_ready", r), in_ready, tbl[r].exp_rdy);
      check($sformatf("tbl%0d_done", r), done, tbl[r].exp_done);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("done_dut_reset", dut_reset, 0);
    check("done_busy", busy, 0);
    check("done_timeout", timeout, 0);

    // Randomised run from DONE with gapped config and stimulus, stray start pulses
    for (int i = 0; i < RC; i++) cfg_words[i] = $urandom;
    start_seq();
    feed_config(1'b1);
    reset_window();
    target = TO_EN ? int'($urandom_range(2, 6)) : int'($urandom_range(5, 20));
    sent = 0;
    guard = 0;
    prev_xfer = 1'b0;
    prev_val = 32'h0;
    iv_model = input_vector;
    while (sent < target && guard < 500) begin
      in_valid = TO_EN ? 1'b1 : ($urandom_range(0, 2) != 0);
      in_data  = $urandom;
      in_last  = (sent == target - 1);
      start    = ($urandom_range(0, 9) == 0);
      xfer     = in_valid;
      tick();
      if (xfer) begin
        iv_model = in_data;
        sent++;
      end
      check("rnd_input_vector", input_vector, iv_model);
      check("rnd_out_valid", out_valid, prev_xfer);
      if (prev_xfer) check("rnd_out_data", out_data, prev_val + 32'd1);
      if (out_valid) $display("resp: out_data=%h", out_data);
      prev_xfer = xfer;
      prev_val  = iv_model;
      guard++;
    end
    check("rnd_sent", sent, target);
    start    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    tick();
    check("rnd_last_out_valid", out_valid, 1);
    check("rnd_last_out_data", out_data, iv_model + 32'd1);
    check("rnd_drain_done", done, 0);
    tick();
    check("rnd_done", done, 1);
    check("rnd_done_out_valid", out_valid, 0);

    // Reset asserted in CONFIG after 7 words discards everything
    start_seq();
    cfg_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      cfg_data = 32'h100 + 32'(i);
      tick();
    end
    cfg_valid = 1'b0;
    check("mid_busy_before", busy, 1);
    logic_reset_n = 1'b0;
    #1;
    check_reset_values("midrst");
    for (int i = 0; i < RC; i++) exp_regs[i] = '0;
    tick();
    logic_reset_n = 1'b1;
    tick();
    check_reset_values("midrst_idle");

`ifdef VECTOR_SEQUENCER_TIMEOUT_EN
    // Watchdog: no in_last, one transfer on the final RUN cycle
    for (int i = 0; i < RC; i++) cfg_words[i] = 32'h200 + 32'(i);
    start_seq();
    feed_config(1'b0);
    reset_window();
    n = 0;
    to_data = 32'hCAFE_0001;
    while (done !== 1'b1 && n < 50) begin
      in_valid = (n == MAXC - 1);
      in_data  = to_data;
      tick();
      n++;
    end
    in_valid = 1'b0;
    check("to_run_cycles", n, MAXC);
    check("to_timeout", timeout, 1);
    check("to_input_vector", input_vector, to_data);
    tick();
    check("to_final_out_valid", out_valid, 1);
    check("to_final_out_data", out_data, to_data + 32'd1);
    check("to_timeout_sticky", timeout, 1);
    start_seq();
`else
    n = 0;
    to_data = 32'h0;
    check("no_timeout_tied", timeout, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vector_sequencer.md
# vector_sequencer

Synthesizable controller that sequences one device-under-test run: it loads the configuration register array from a word stream, holds the DUT in reset for a fixed number of cycles, then streams input vectors to the DUT one per accepted handshake and returns the sampled output vectors. It sits between host-side stimulus/response streams and the DUT, replacing file-driven testbench sequencing with hardware sequencing.

## Interface
- register_size, 32, width of one configuration register
- register_count, 32, number of configuration registers (≥1)
- input_vector_size, 32, DUT input vector width
- output_vector_size, 32, DUT output vector width
- reset_cycles, 5, cycles dut_reset held in RESET state (≥1)
- max_cycles, 10000, RUN-state cycle limit (watchdog only)
- clk  in  1  single clock, rising edge
- logic_reset_n  in  1  asynchronous, active-low reset
- start  in  1  begin a sequence; honoured only in IDLE or DONE
- cfg_data  in  register_size  configuration word
- cfg_valid  in  1 / cfg_ready  out  1  configuration handshake
- config_regs  out  register_count*register_size  register i at [i*register_size +: register_size]
- dut_reset  out  1  active-high DUT reset
- in_data  in  input_vector_size / in_valid  in  1 / in_last  in  1 / in_ready  out  1  stimulus stream
- input_vector  out  input_vector_size  registered DUT input
- dut_output  in  output_vector_size  DUT output
- out_data  out  output_vector_size / out_valid  out  1  sampled response
- busy  out  1  state not IDLE/DONE
- done  out  1  state DONE
- timeout  out  1  sticky watchdog flag

## Operation
- Reset values: cfg_ready 0, in_ready 0, config_regs 0, dut_reset 1, input_vector 0, out_data 0, out_valid 0, busy 0, done 0, timeout 0; state IDLE.
- Handshake: transfer when valid & ready at rising edge; ready does not depend on valid.
- IDLE: dut_reset 1. start → CONFIG, cfg_cnt ← 0.
- CONFIG: cfg_ready 1; each transfer writes config_regs[cfg_cnt], cfg_cnt++. Transfer with cfg_cnt == register_count-1 → RESET; cfg_ready drops next cycle (surplus words are never accepted).
- RESET: dut_reset 1 for exactly reset_cycles cycles, then → RUN; dut_reset 0 from RUN onward.
- RUN: in_ready 1; transfer loads input_vector ← in_data. Transfer with in_last → DRAIN. No transfer: input_vector holds, no out_valid generated (bubble).
- DRAIN: 2 cycles, in_ready 0, lets last response emerge, → DONE.
- DONE: done 1; input_vector, config_regs hold; dut_reset 0. start → CONFIG (cfg_cnt cleared, timeout cleared; config_regs keep old values until overwritten).
- start outside IDLE/DONE ignored.
- logic_reset_n asserted mid-operation: immediate return to IDLE with all reset values; partial configuration discarded.
- Counter widths: cfg_cnt $clog2(register_count) (min 1); run cycle counter $clog2(max_cycles+1).

## Timing
- Input transfer at edge N → input_vector valid after N; out_data ← dut_output and out_valid 1 at edge N+1 (single-cycle pulse per transfer). Back-to-back transfers give back-to-back out_valid.
- Last config transfer at edge N → dut_reset 1 through edge N+reset_cycles, 0 after; in_ready 1 in same cycle dut_reset drops.
- in_last transfer at edge N → its out_valid at N+1, done 1 after N+2.
- start registered: state changes one edge after start sampled.

## Configuration
- VECTOR_SEQUENCER_TIMEOUT_EN defined: counter counts RUN cycles; reaching max_cycles forces → DONE with timeout 1 (sticky until next start); outstanding out_valid for the final transfer still issued.
- Undefined: no counter, timeout tied 0, RUN ends only on in_last.

## Structure
- Shared package vector_sequencer_pkg: state enum (IDLE, CONFIG, RESET, RUN, DRAIN, DONE).
- One sub-module: config_regfile (write port addr/data/en, flattened read-out, async reset to 0).

## Test plan
- start, 32 config words 0x00000000..0x0000001F → config_regs[i]==i, cfg_ready low after 32nd word, 33rd word never accepted.
- After config → dut_reset high exactly 5 cycles, then in_ready 1.
- DUT modelled as output=input+1, stream 0x10,0x11,0x12 (last) → out_data 0x11,0x12,0x13, each 1 cycle after transfer, done after 2 more edges.
- in_valid gaps in RUN → input_vector holds, no out_valid during gaps.
- logic_reset_n low during CONFIG after 7 words → all outputs reset values, state IDLE, config_regs all 0.
- With VECTOR_SEQUENCER_TIMEOUT_EN, max_cycles 8, in_last never sent → DONE after 8 RUN cycles, timeout 1; next start clears it.
